pipe_buf_stage: RTL and testbench

- Generic, parametrised pipeline stage register, the successor to the fixed IF/ID, ID/EX, EX/MEM and MEM/WB struct registers.
- Carries an opaque payload of DATA_W bits, for example the packed bits of any stage struct.
- Adds a valid/ready handshake, a 2-entry skid buffer for back-pressure (stall), synchronous flush, and bubble insertion.
- One instance sits between each pair of pipeline stages.

---
 rtl/pipe_buf_pkg.sv | 63 ++++++
 rtl/pipe_buf_if.sv | 38 +++
 rtl/pipe_buf_perf_cnt.sv | 31 +++
 rtl/pipe_buf_stage.sv | 124 ++++++++++++
 tb/tb_pipe_buf_stage.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/pipe_buf_pkg.sv
// Shared types for the generic pipeline buffer stage.
// Stage payload widths are derived from the stage structs below.
package pipe_buf_pkg;

    typedef enum logic [1:0] {
        PB_EMPTY = 2'd0,
        PB_ONE   = 2'd1,
        PB_FULL  = 2'd2
    } pb_state_e;

    localparam int PC_W = 9;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [31:0]     instr;
    } if_id_t;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [31:0]     rs1_val;
        logic [31:0]     rs2_val;
        logic [31:0]     imm;
        logic [4:0]      rd;
        logic [3:0]      alu_op;
        logic            mem_rd;
        logic            mem_wr;
        logic            reg_wr;
    } id_ex_t;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [31:0]     alu_res;
        logic [31:0]     rs2_val;
        logic [4:0]      rd;
        logic            mem_rd;
        logic            mem_wr;
        logic            reg_wr;
    } ex_mem_t;

    typedef struct packed {
        logic [31:0] wb_data;
        logic [4:0]  rd;
        logic        reg_wr;
    } mem_wb_t;

    localparam int IF_ID_W  = $bits(if_id_t);
    localparam int ID_EX_W  = $bits(id_ex_t);
    localparam int EX_MEM_W = $bits(ex_mem_t);
    localparam int MEM_WB_W = $bits(mem_wb_t);

    function automatic logic [1:0] pb_occ(pb_state_e s);
        logic [1:0] occ;
        occ = 2'd0;
        unique case (s)
            PB_ONE:  occ = 2'd1;
            PB_FULL: occ = 2'd2;
            default: occ = 2'd0;
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/pipe_buf_if.sv
// Upstream/downstream handshake bundle around one pipeline buffer stage.
// The slave modport is the stage's view; master is the surrounding logic.
interface pipe_buf_if #(
    parameter int DATA_W = 41
) ();

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              flush;
    logic [1:0]        occupancy;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        output flush,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  occupancy
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        input  flush,
        output in_ready,
        output out_valid,
        output out_data,
        output occupancy
    );

endinterface

// File: rtl/pipe_buf_perf_cnt.sv
// Saturating event counter with enable, async active-low reset.
module pipe_buf_perf_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pipe_buf_stage.sv
// Generic pipeline register: valid/ready, 2-entry skid, flush, bubbles.
// Define PIPE_BUF_PERF_EN to add the stall_cnt/flush_cnt counter ports.
module pipe_buf_stage
    import pipe_buf_pkg::*;
#(
    parameter int                DATA_W     = 41,
    parameter logic [DATA_W-1:0] BUBBLE_VAL = '0,
    parameter int                CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef PIPE_BUF_PERF_EN
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
`endif
    pipe_buf_if.slave        bus
);

    pb_state_e         state_q;
    pb_state_e         state_d;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] main_d;
    logic [DATA_W-1:0] skid_q;
    logic [DATA_W-1:0] skid_d;

    logic in_rdy;
    logic out_vld;
    logic xfer_in;
    logic xfer_out;

    // Handshake outputs come from state only, never from out_ready.
    assign in_rdy  = rst_n && (state_q != PB_FULL);
    assign out_vld = (state_q == PB_ONE) || (state_q == PB_FULL);

    assign xfer_in  = bus.in_valid && in_rdy;
    assign xfer_out = out_vld && bus.out_ready;

    assign bus.in_ready  = in_rdy;
    assign bus.out_valid = out_vld;
    assign bus.out_data  = out_vld ? main_q : BUBBLE_VAL;
    assign bus.occupancy = pb_occ(state_q);

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (bus.flush) begin
            state_d = PB_EMPTY;
            main_d  = BUBBLE_VAL;
            skid_d  = BUBBLE_VAL;
        end else begin
            unique case (state_q)
                PB_EMPTY: begin
                    if (xfer_in) begin
                        state_d = PB_ONE;
                        main_d  = bus.in_data;
                    end
                end
                PB_ONE: begin
                    if (xfer_in && xfer_out) begin
                        main_d = bus.in_data;
                    end else if (xfer_in) begin
                        state_d = PB_FULL;
                        skid_d  = bus.in_data;
                    end else if (xfer_out) begin
                        state_d = PB_EMPTY;
                        main_d  = BUBBLE_VAL;
                    end
                end
                PB_FULL: begin
                    if (xfer_out) begin
                        state_d = PB_ONE;
                        main_d  = skid_q;
                        skid_d  = BUBBLE_VAL;
                    end
                end
                default: begin
                    state_d = PB_EMPTY;
                    main_d  = BUBBLE_VAL;
                    skid_d  = BUBBLE_VAL;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= PB_EMPTY;
            main_q  <= BUBBLE_VAL;
            skid_q  <= BUBBLE_VAL;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

`ifdef PIPE_BUF_PERF_EN
    logic stall_ev;
    logic flush_ev;

    assign stall_ev = out_vld && !bus.out_ready;
    assign flush_ev = bus.flush && (state_q != PB_EMPTY);

    pipe_buf_perf_cnt #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (stall_ev),
        .cnt   (stall_cnt)
    );

    pipe_buf_perf_cnt #(
        .CNT_W (CNT_W)
    ) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (flush_ev),
        .cnt   (flush_cnt)
    );
`endif

endmodule

// File: tb/tb_pipe_buf_stage.sv
// Directed bench for pipe_buf_stage: vector table plus reset/perf sequences.
module tb_pipe_buf_stage;

    localparam int DW = 41;
    localparam int CW = 4;
    localparam logic [DW-1:0] BUB = '0;

    logic clk;
    logic rst_n;

    pipe_buf_if #(.DATA_W(DW)) bus ();

`ifdef PIPE_BUF_PERF_EN
    logic [CW-1:0] stall_cnt;
    logic [CW-1:0] flush_cnt;
`endif

    pipe_buf_stage #(
        .DATA_W     (DW),
        .BUBBLE_VAL (BUB),
        .CNT_W      (CW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef PIPE_BUF_PERF_EN
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt),
`endif
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          iv;
        logic [DW-1:0] id;
        logic          ordy;
        logic          fl;
        logic          ov;
        logic [DW-1:0] od;
        logic          ir;
        logic [1:0]    occ;
    } vec_t;

    vec_t vecs[$];
    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic add(input logic iv, input logic [DW-1:0] id,
                       input logic ordy, input logic fl,
                       input logic ov, input logic [DW-1:0] od,
                       input logic ir, input logic [1:0] occ);
        vec_t v;
        v.iv = iv; v.id = id; v.ordy = ordy; v.fl = fl;
        v.ov = ov; v.od = od; v.ir = ir; v.occ = occ;
        vecs.push_back(v);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic iv, input logic [DW-1:0] id,
                         input logic ordy, input logic fl);
        bus.in_valid  = iv;
        bus.in_data   = id;
        bus.out_ready = ordy;
        bus.flush     = fl;
    endtask

    initial begin
        logic [DW-1:0] ones;
        ones = '1;

        // streaming
        add(1, 41'h1,  1, 0,  1, 41'h1,  1, 2'd1);
        add(1, 41'h2,  1, 0,  1, 41'h2,  1, 2'd1);
        add(1, 41'h3,  1, 0,  1, 41'h3,  1, 2'd1);
        add(1, 41'h4,  1, 0,  1, 41'h4,  1, 2'd1);
        add(0, 41'h0,  1, 0,  0, BUB,    1, 2'd0);
        // stall into FULL, then drain in order
        add(1, 41'hAA, 0, 0,  1, 41'hAA, 1, 2'd1);
        add(1, 41'hBB, 0, 0,  1, 41'hAA, 0, 2'd2);
        add(1, 41'hDD, 0, 0,  1, 41'hAA, 0, 2'd2);
        add(0, 41'h0,  1, 0,  1, 41'hBB, 1, 2'd1);
        add(0, 41'h0,  1, 0,  0, BUB,    1, 2'd0);
        add(0, 41'h0,  0, 0,  0, BUB,    1, 2'd0);
        // ONE hold, in&out replace, then FULL
        add(1, 41'h55, 0, 0,  1, 41'h55, 1, 2'd1);
        add(0, 41'h0,  0, 0,  1, 41'h55, 1, 2'd1);
        add(1, 41'h66, 1, 0,  1, 41'h66, 1, 2'd1);
        add(1, 41'h77, 0, 0,  1, 41'h66, 0, 2'd2);
        // flush in FULL with a pending input
        add(1, 41'hCC, 0, 1,  0, BUB,    1, 2'd0);
        add(0, 41'h0,  1, 0,  0, BUB,    1, 2'd0);
        // flush in ONE with out transfer, flush in EMPTY
        add(1, 41'h11, 1, 0,  1, 41'h11, 1, 2'd1);
        add(1, 41'h22, 1, 1,  0, BUB,    1, 2'd0);
        add(1, 41'h33, 1, 1,  0, BUB,    1, 2'd0);
        add(1, 41'h44, 1, 0,  1, 41'h44, 1, 2'd1);
        add(0, 41'h0,  1, 0,  0, BUB,    1, 2'd0);
        // full-width payload
        add(1, ones,   1, 0,  1, ones,   1, 2'd1);
        add(0, 41'h0,  1, 0,  0, BUB,    1, 2'd0);

        // reset held with input offered
        rst_n = 1'b0;
        drive(1, 41'h1, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_data",  64'(bus.out_data),  64'(BUB));
        chk("rst_in_ready",  64'(bus.in_ready),  64'd0);
        chk("rst_occupancy", 64'(bus.occupancy), 64'd0);
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready", 64'(bus.in_ready), 64'd1);
`ifdef PIPE_BUF_PERF_EN
        chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);
        chk("rst_flush_cnt", 64'(flush_cnt), 64'd0);
`endif
        step();

        foreach (vecs[i]) begin
            drive(vecs[i].iv, vecs[i].id, vecs[i].ordy, vecs[i].fl);
            step();
            chk($sformatf("v%0d_out_valid", i),
                64'(bus.out_valid), 64'(vecs[i].ov));
            chk($sformatf("v%0d_out_data", i),
                64'(bus.out_data), 64'(vecs[i].od));
            chk($sformatf("v%0d_in_ready", i),
                64'(bus.in_ready), 64'(vecs[i].ir));
            chk($sformatf("v%0d_occupancy", i),
                64'(bus.occupancy), 64'(vecs[i].occ));
        end

        // asynchronous reset while FULL
        drive(1, 41'hAA, 0, 0);
        step();
        bus.in_data = 41'hBB;
        step();
        chk("pre_rst_occ", 64'(bus.occupancy), 64'd2);
        #3;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("mid_rst_out_data",  64'(bus.out_data),  64'(BUB));
        chk("mid_rst_in_ready",  64'(bus.in_ready),  64'd0);
        chk("mid_rst_occupancy", 64'(bus.occupancy), 64'd0);
        bus.in_valid = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        drive(1, 41'h5A, 0, 0);
        step();
        chk("post_rst_data", 64'(bus.out_data),  64'h5A);
        chk("post_rst_occ",  64'(bus.occupancy), 64'd1);
        drive(0, 41'h0, 1, 0);
        step();
        chk("post_rst_drain_valid", 64'(bus.out_valid), 64'd0);
        chk("post_rst_drain_data",  64'(bus.out_data),  64'(BUB));

`ifdef PIPE_BUF_PERF_EN
        chk("perf_stall_zero", 64'(stall_cnt), 64'd0);
        drive(1, 41'h9, 0, 0);
        step();
        bus.in_valid = 1'b0;
        repeat (20) step();
        chk("perf_stall_sat", 64'(stall_cnt), 64'hF);
        chk("perf_flush_zero", 64'(flush_cnt), 64'd0);
        bus.flush = 1'b1;
        step();
        chk("perf_flush_one", 64'(flush_cnt), 64'd1);
        chk("perf_flush_occ", 64'(bus.occupancy), 64'd0);
        step();
        chk("perf_flush_empty", 64'(flush_cnt), 64'd1);
        chk("perf_stall_kept", 64'(stall_cnt), 64'hF);
        bus.flush = 1'b0;
        step();
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
